// File: rtl/ransac_fixed_pkg.sv
// ransac_fixed: shared Q16.16 fixed-point type, FMA opcodes and width helpers
package ransac_fixed;
  localparam int VALUE_BITS = 32;
  localparam int FRAC_BITS = 16;
  typedef logic signed [VALUE_BITS-1:0] fixed_t;
  typedef enum logic {
    FMA_OPCODE_POS_A_POS_C = 1'b0,
    FMA_OPCODE_NEG_A_POS_C = 1'b1
  } fma_opcode_t;
  function automatic int value_bits();
    return VALUE_BITS;
  endfunction
endpackage

// File: rtl/param_vector_squared_magnitude.sv
// param_vector_squared_magnitude: sum vector[i]^2 using the dot product with lhs = rhs and zero bias
module param_vector_squared_magnitude
  import ransac_fixed::*;
#(
  parameter int dimension = 3,
  parameter int multiply_latency = ransac_fixed::value_bits() / 8
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   input_valid,
  input  fixed_t vector [dimension],
  output logic   input_ready,
  output logic   output_valid,
  input  logic   output_ready,
  output fixed_t magnitude
);
  param_vector_dot_product #(.dimension(dimension), .multiply_latency(multiply_latency)) u_dot (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .lhs          (vector),
    .rhs          (vector),
    .bias         ('0),
`ifdef PARAM_DOT_PRODUCT_SUBTRACT_EN
    .subtract     (1'b0),
`endif
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .dot_product  (magnitude)
  );
endmodule

// File: rtl/slow_fp_fused_multiply_add.sv
// slow_fp_fused_multiply_add: pipelined fixed-point r = c +/- a*b, result valid `latency` cycles after input_valid
module slow_fp_fused_multiply_add
  import ransac_fixed::*;
#(
  parameter int latency = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        input_valid,
  input  fixed_t      a,
  input  fixed_t      b,
  input  fixed_t      c,
  input  fma_opcode_t opcode,
  output logic        output_valid,
  output fixed_t      r
);
  logic [latency-1:0] r_valid;
  fixed_t r_result [latency];
  logic signed [2*VALUE_BITS-1:0] w_a, w_b, w_product;
  fixed_t w_term, w_result;
  if (latency < 1) begin : g_latency_check
    $error("slow_fp_fused_multiply_add: latency must be >= 1");
  end
  // Full-width product rescaled by truncation; overflow wraps in fixed_t
  always_comb begin
    w_a = {{VALUE_BITS{a[VALUE_BITS-1]}}, a};
    w_b = {{VALUE_BITS{b[VALUE_BITS-1]}}, b};
    w_product = w_a * w_b;
    w_term = fixed_t'(w_product >>> FRAC_BITS);
    w_result = (opcode == FMA_OPCODE_NEG_A_POS_C) ? c - w_term : c + w_term;
  end
  // Valid shift chain; reset flushes any result in flight
  always_ff @(posedge clock) begin
    if (reset) r_valid <= '0;
    else begin
      r_valid[0] <= input_valid;
      for (int k = 1; k < latency; k++) r_valid[k] <= r_valid[k-1];
    end
  end
  // Result shift chain travelling alongside the valid bits
  always_ff @(posedge clock) begin
    r_result[0] <= w_result;
    for (int k = 1; k < latency; k++) r_result[k] <= r_result[k-1];
  end
  assign output_valid = r_valid[latency-1];
  assign r = r_result[latency-1];
endmodule

// File: rtl/param_vector_dot_product.sv
// param_vector_dot_product: bias + sum lhs[i]*rhs[i] via one serial FMA; PARAM_DOT_PRODUCT_SUBTRACT_EN adds a subtract port
module param_vector_dot_product
  import ransac_fixed::*;
#(
  parameter int dimension = 3,
  parameter int multiply_latency = ransac_fixed::value_bits() / 8
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   input_valid,
  input  fixed_t lhs [dimension],
  input  fixed_t rhs [dimension],
  input  fixed_t bias,
`ifdef PARAM_DOT_PRODUCT_SUBTRACT_EN
  input  logic   subtract,
`endif
  output logic   input_ready,
  output logic   output_valid,
  input  logic   output_ready,
  output fixed_t dot_product
);
  localparam int IW = (dimension > 1) ? $clog2(dimension) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  fixed_t r_lhs [dimension];
  fixed_t r_rhs [dimension];
  fixed_t r_acc, r_dot, w_fma_r;
  logic [IW-1:0] r_i;
  logic r_output_valid, w_accept, w_last, w_fma_valid, w_fma_out_valid;
  fma_opcode_t w_opcode;
`ifdef PARAM_DOT_PRODUCT_SUBTRACT_EN
  logic r_subtract;
`endif
  if (dimension < 1) begin : g_dimension_check
    $error("param_vector_dot_product: dimension must be >= 1");
  end
  // Handshake decode, FMA issue strobe, opcode and next state
  always_comb begin
    w_accept = (r_state == IDLE) && input_valid;
    w_last = r_i == IW'(dimension - 1);
    w_fma_valid = r_state == ISSUE;
`ifdef PARAM_DOT_PRODUCT_SUBTRACT_EN
    w_opcode = r_subtract ? FMA_OPCODE_NEG_A_POS_C : FMA_OPCODE_POS_A_POS_C;
`else
    w_opcode = FMA_OPCODE_POS_A_POS_C;
`endif
    w_next = w_accept ? ISSUE :
             (r_state == ISSUE) ? WAIT :
             (r_state == WAIT && w_fma_out_valid) ? (w_last ? DONE : ISSUE) :
             (r_state == DONE && r_output_valid && output_ready) ? IDLE : r_state;
  end
  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Operands are captured at accept so the caller may change them afterwards
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lhs <= lhs;
      r_rhs <= rhs;
`ifdef PARAM_DOT_PRODUCT_SUBTRACT_EN
      r_subtract <= subtract;
`endif
    end
  end
  // Accumulate in index order; output_valid rises the cycle after entering DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i <= '0;
      r_acc <= '0;
      r_dot <= '0;
      r_output_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_i <= '0;
        r_acc <= bias;
      end
      if (r_state == WAIT && w_fma_out_valid) begin
        r_acc <= w_fma_r;
        if (w_last) r_dot <= w_fma_r;
        else r_i <= r_i + 1'b1;
      end
      if (r_state == DONE) r_output_valid <= !(r_output_valid && output_ready);
    end
  end
  slow_fp_fused_multiply_add #(.latency(multiply_latency)) u_fma (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (w_fma_valid),
    .a            (r_lhs[r_i]),
    .b            (r_rhs[r_i]),
    .c            (r_acc),
    .opcode       (w_opcode),
    .output_valid (w_fma_out_valid),
    .r            (w_fma_r)
  );
  assign input_ready = r_state == IDLE;
  assign output_valid = r_output_valid;
  assign dot_product = r_dot;
endmodule

// File: doc/param_vector_dot_product.md
# param_vector_dot_product

Parametrised fixed-point dot product over `dimension`-element vectors, with an optional bias term and output back-pressure. It computes `bias + Σ lhs[i]·rhs[i]` by issuing one fused multiply-add per element to a single `slow_fp_fused_multiply_add`. It is the general replacement for the fixed 3-element dot product and serves plane fitting, distance, and N-dimensional RANSAC model evaluation at once-per-model rates.

## Interface
Parameters:
- `dimension`, default 3: element count per vector; must be ≥ 1 (elaboration-time assertion).
- `multiply_latency`, default `ransac_fixed::value_bits() / 8`: passed to the internal FMA.

Ports:
- `clock`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `input_valid`, input, 1: operands present.
- `lhs`, input, `ransac_fixed::fixed_t [dimension]`: left vector.
- `rhs`, input, `ransac_fixed::fixed_t [dimension]`: right vector.
- `bias`, input, `ransac_fixed::fixed_t`: accumulator initial value.
- `input_ready`, output, 1: block idle and accepting.
- `output_valid`, output, 1: `dot_product` valid; held until consumed.
- `output_ready`, input, 1: consumer accepts the result.
- `dot_product`, output, `ransac_fixed::fixed_t`: result.

## Operation
- **Accept.** An accept happens on a clock edge where `input_valid && input_ready`. On accept, `lhs`, `rhs` and `bias` are registered internally, so the inputs may change afterwards. Index `i` is set to 0, the accumulator `acc` is set to `bias`, and `input_ready` drops.
- **States:**
  - **IDLE:** `input_ready` = 1. On accept, go to ISSUE.
  - **ISSUE:** present `a = lhs[i]`, `b = rhs[i]`, `c = acc` to the FMA. Pulse `fma_input_valid` for exactly one cycle, then go to WAIT.
  - **WAIT:** `fma_input_valid` = 0. When `fma_output_valid` is seen, `acc <= fma_r`.
    - If `i == dimension-1`, load `dot_product <= fma_r`, set `output_valid` = 1, and go to DONE.
    - Otherwise increment `i` and go to ISSUE.
  - **DONE:** hold `output_valid` and `dot_product`. When `output_ready` = 1, clear `output_valid` and go to IDLE.
- **Ordering.** Elements are accumulated in index order 0 to `dimension-1`.
- **Arithmetic.** All arithmetic is `fixed_t` with FMA rounding and overflow semantics. No widening is applied. `i` is `max(1, $clog2(dimension))` bits.
- **Busy inputs.** `input_valid` while busy is ignored; nothing is queued.
- **Reset mid-operation.** Return to IDLE and discard the in-flight FMA result; the FMA shares `reset`.
- **Reset values:** `input_ready` = 1, `output_valid` = 0, `dot_product` = 0, `fma_input_valid` = 0.
- **`dimension` = 1.** The path is ISSUE, then WAIT, then DONE, producing `bias + lhs[0]·rhs[0]`.

## Timing
- Let L be the FMA's cycles from the cycle `fma_input_valid` is sampled to `fma_output_valid`.
- `output_valid` rises `dimension·(L+1) + 1` edges after the accept edge.
- The handshake completes on the first edge where `output_valid && output_ready`. `input_ready` is 1 on the following cycle.
- Minimum accept-to-accept interval: `dimension·(L+1) + 3` cycles.
- There is no combinational path from any input to any output.

## Configuration
- `PARAM_DOT_PRODUCT_SUBTRACT_EN`:
  - **Defined:** adds input port `subtract` (1 bit), sampled at accept. When `subtract` = 1, every FMA uses opcode `ransac_fixed::FMA_OPCODE_NEG_A_POS_C`, so the result is `bias − Σ lhs[i]·rhs[i]`. Timing is unchanged.
  - **Undefined:** the port is absent and the opcode is always `FMA_OPCODE_POS_A_POS_C`.

## Structure
- **`ransac_fixed` package.** `fixed_t` and FMA opcodes come from here. Add a `vectornf_t` typedef helper only if other blocks need it. The state enum stays local to the module.
- **Sub-module.** One `slow_fp_fused_multiply_add` instance with `latency = multiply_latency`. No other sub-modules.
- **Wrapper.** Add a thin wrapper, `param_vector_squared_magnitude`, that ties `lhs = rhs` and `bias = 0`.

## Test plan
- **Basic sum.** `dimension=3`, `lhs=(1,2,3)`, `rhs=(4,5,6)`, `bias=0`, `output_ready=1` → `dot_product=32`, with `output_valid` rising exactly `3(L+1)+1` cycles after accept.
- **Bias and back-pressure.** `dimension=4`, `lhs=(1,1,1,1)`, `rhs=(0.5,−2,3,0)`, `bias=10` → 11.5. Hold `output_ready=0` for 5 cycles: `output_valid` and `dot_product` stay stable and `input_ready=0` throughout.
- **Minimum dimension.** `dimension=1`, `lhs=(−3)`, `rhs=(2)`, `bias=1` → −5. Drive a second request during busy: it is ignored, and is accepted only after `input_ready` returns.
- **Reset mid-operation.** Assert reset during WAIT of element 1 → next cycle `input_ready=1`, `output_valid=0`, `dot_product=0`. A fresh request then gives the correct result.
- **Back-to-back.** Run the basic-sum request twice with `input_valid` held high → the second accept occurs exactly `3(L+1)+3` cycles after the first, and both results are 32.
- **Subtract mode (macro defined).** `lhs=(1,2,3)`, `rhs=(4,5,6)`, `bias=40`, `subtract=1` → 8. With `subtract=0` → 72.
